// File: rtl/exe_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exe_muldiv_ctrl
// Purpose  : Iterative multiply/divide sequencer beside the EXE-stage ALU.
//            Executes MULTU/MULT (shift-add) and DIVU/DIV (restoring) in
//            WIDTH iterations, stalls the pipeline while running and owns
//            the architectural HI/LO registers (also written by MTHI/MTLO).
// Ports    : clk, rst       - clock, synchronous active-high reset
//            i_MD_start     - one-cycle start request
//            i_MD_op        - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//            i_MD_a/i_MD_b  - operands (rs/rt)
//            i_MD_mthi/mtlo - write i_MD_wdata into HI/LO (idle only)
//            o_MD_busy      - pipeline stall, high whenever not idle
//            o_MD_done      - one-cycle pulse, HI/LO freshly updated
//            o_MD_hi/o_MD_lo- HI/LO registers
// Revision : 1.0 - initial release
// ============================================================================
module exe_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_MD_start,
    input  logic [1:0]       i_MD_op,
    input  logic [WIDTH-1:0] i_MD_a,
    input  logic [WIDTH-1:0] i_MD_b,
    input  logic             i_MD_mthi,
    input  logic             i_MD_mtlo,
    input  logic [WIDTH-1:0] i_MD_wdata,
    output logic             o_MD_busy,
    output logic             o_MD_done,
    output logic [WIDTH-1:0] o_MD_hi,
    output logic [WIDTH-1:0] o_MD_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_LAST_CNT = CW'(WIDTH - 1);

    state_t             state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic [1:0]         op_q,      op_d;
    // Multiplicand (MUL) or divisor (DIV), always a magnitude
    logic [WIDTH-1:0]   opnd_q,    opnd_d;
    // MUL: {partial product hi, multiplier/product lo}; DIV: {remainder, quotient}
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               bzero_q,   bzero_d;
    logic               done_q,    done_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;

    // ------------------------------------------------------------------
    // Operand magnitudes at start. 0x80000000 negates to itself, which is
    // the correct magnitude once treated as unsigned.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    always_comb begin
        w_abs_a = (i_MD_op[0] && i_MD_a[WIDTH-1]) ? (~i_MD_a + 1'b1) : i_MD_a;
        w_abs_b = (i_MD_op[0] && i_MD_b[WIDTH-1]) ? (~i_MD_b + 1'b1) : i_MD_b;
    end

    // ------------------------------------------------------------------
    // One shift-add multiply step: conditional add into the upper half,
    // the carry becomes the new MSB after the right shift.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    always_comb begin
        w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};
    end

    // ------------------------------------------------------------------
    // One restoring divide step. The shifted remainder needs WIDTH+1 bits;
    // when the trial subtraction fits, the difference is below the divisor
    // and therefore fits back into WIDTH bits. With a zero divisor every
    // step "fits", so the quotient fills with ones and the remainder ends
    // up holding the dividend.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_rem_sh;
    logic               w_fits;
    logic [WIDTH-1:0]   w_sub;
    logic [2*WIDTH-1:0] w_div_next;

    always_comb begin
        w_rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        w_fits     = (w_rem_sh >= {1'b0, opnd_q});
        w_sub      = w_rem_sh[WIDTH-1:0] - opnd_q;
        w_div_next = {(w_fits ? w_sub : w_rem_sh[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], w_fits};
    end

    // ------------------------------------------------------------------
    // Sign correction applied in FIX.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    always_comb begin
        w_prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        // Divide by zero always reports an all-ones quotient, regardless of sign
        if (bzero_q) begin
            w_quo_fix = {WIDTH{1'b1}};
        end else if (neg_res_q) begin
            w_quo_fix = ~acc_q[WIDTH-1:0] + 1'b1;
        end else begin
            w_quo_fix = acc_q[WIDTH-1:0];
        end
        w_rem_fix = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                              : acc_q[2*WIDTH-1:WIDTH];
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (i_MD_start) begin
                    op_d      = i_MD_op;
                    opnd_d    = i_MD_op[1] ? w_abs_b : w_abs_a;
                    acc_d     = {{WIDTH{1'b0}}, (i_MD_op[1] ? w_abs_a : w_abs_b)};
                    neg_res_d = i_MD_op[0] & (i_MD_a[WIDTH-1] ^ i_MD_b[WIDTH-1]);
                    neg_rem_d = i_MD_op[0] & i_MD_a[WIDTH-1];
                    bzero_d   = (i_MD_b == {WIDTH{1'b0}});
                    cnt_d     = {CW{1'b0}};
                    state_d   = S_CALC;
                end else begin
                    // Start has priority, so MT writes only land here
                    if (i_MD_mthi) begin
                        hi_d = i_MD_wdata;
                    end
                    if (i_MD_mtlo) begin
                        lo_d = i_MD_wdata;
                    end
                end
            end

            S_CALC: begin
                acc_d = op_q[1] ? w_div_next : w_mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_LAST_CNT) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (op_q[1]) begin
                    hi_d = w_rem_fix;
                    lo_d = w_quo_fix;
                end else begin
                    hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = w_prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            op_q      <= 2'b00;
            opnd_q    <= {WIDTH{1'b0}};
            acc_q     <= {(2*WIDTH){1'b0}};
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign o_MD_busy = (state_q != S_IDLE);
    assign o_MD_done = done_q;
    assign o_MD_hi   = hi_q;
    assign o_MD_lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_exe_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_muldiv_ctrl
// Purpose  : Self-checking bench for exe_muldiv_ctrl. Expected HI/LO values
//            come from plain 64-bit arithmetic on the operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_muldiv_ctrl;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_MD_start;
    logic [1:0]       i_MD_op;
    logic [WIDTH-1:0] i_MD_a;
    logic [WIDTH-1:0] i_MD_b;
    logic             i_MD_mthi;
    logic             i_MD_mtlo;
    logic [WIDTH-1:0] i_MD_wdata;
    logic             o_MD_busy;
    logic             o_MD_done;
    logic [WIDTH-1:0] o_MD_hi;
    logic [WIDTH-1:0] o_MD_lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    exe_muldiv_ctrl #(.WIDTH(WIDTH), .CW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_MD_start (i_MD_start),
        .i_MD_op    (i_MD_op),
        .i_MD_a     (i_MD_a),
        .i_MD_b     (i_MD_b),
        .i_MD_mthi  (i_MD_mthi),
        .i_MD_mtlo  (i_MD_mtlo),
        .i_MD_wdata (i_MD_wdata),
        .o_MD_busy  (o_MD_busy),
        .o_MD_done  (o_MD_done),
        .o_MD_hi    (o_MD_hi),
        .o_MD_lo    (o_MD_lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural result {HI, LO} from plain arithmetic
    function automatic logic [63:0] ref_md(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: p = {32'h0, a} * {32'h0, b};
            2'd1: p = sa * sb;
            2'd2: p = (b == 32'h0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: begin
                if (b == 32'h0) begin
                    p = {a, 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // Drives a start (optionally with MT requests) for one cycle.
    // Entered and left at a falling edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mthi, input logic mtlo, input logic [31:0] wd);
        i_MD_start = 1'b1;
        i_MD_op    = op;
        i_MD_a     = a;
        i_MD_b     = b;
        i_MD_mthi  = mthi;
        i_MD_mtlo  = mtlo;
        i_MD_wdata = wd;
        @(negedge clk);
        i_MD_start = 1'b0;
        i_MD_mthi  = 1'b0;
        i_MD_mtlo  = 1'b0;
    endtask

    // Follows the busy window (pre = busy cycles already elapsed) and checks
    // its length, HI/LO holding, and the done-cycle result.
    task automatic wait_done(input string tag, input int pre, input logic [63:0] exp);
        int n;
        n = pre;
        while (o_MD_busy === 1'b1 && n < 60) begin
            chk({tag, "_hold_hi"}, o_MD_hi, m_hi);
            chk({tag, "_hold_lo"}, o_MD_lo, m_lo);
            chk({tag, "_done_early"}, o_MD_done, 1'b0);
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_len"}, n, 33);
        chk({tag, "_done"}, o_MD_done, 1'b1);
        chk({tag, "_hi"}, o_MD_hi, exp[63:32]);
        chk({tag, "_lo"}, o_MD_lo, exp[31:0]);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        launch(op, a, b, 1'b0, 1'b0, 32'h0);
        wait_done(tag, 0, ref_md(op, a, b));
        @(negedge clk);
        chk({tag, "_done_pulse"}, o_MD_done, 1'b0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;

        rst = 1'b1; i_MD_start = 1'b0; i_MD_op = 2'b00; i_MD_a = '0; i_MD_b = '0;
        i_MD_mthi = 1'b0; i_MD_mtlo = 1'b0; i_MD_wdata = '0;

        // Reset and idle
        repeat (2) @(negedge clk);
        chk("rst_hi", o_MD_hi, 32'h0);
        chk("rst_lo", o_MD_lo, 32'h0);
        chk("rst_busy", o_MD_busy, 1'b0);
        chk("rst_done", o_MD_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // MT writes
        i_MD_mthi = 1'b1; i_MD_wdata = 32'h12345678;
        @(negedge clk);
        i_MD_mthi = 1'b0;
        chk("mthi_hi", o_MD_hi, 32'h12345678);
        chk("mthi_lo", o_MD_lo, 32'h0);
        i_MD_mthi = 1'b1; i_MD_mtlo = 1'b1; i_MD_wdata = 32'h0F0F0F0F;
        @(negedge clk);
        i_MD_mthi = 1'b0; i_MD_mtlo = 1'b0;
        chk("mtboth_hi", o_MD_hi, 32'h0F0F0F0F);
        chk("mtboth_lo", o_MD_lo, 32'h0F0F0F0F);
        chk("mt_busy", o_MD_busy, 1'b0);
        m_hi = 32'h0F0F0F0F; m_lo = 32'h0F0F0F0F;

        // Directed arithmetic corners
        run_op("multu_max", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_max_hi_const", m_hi, 32'hFFFFFFFE);
        run_op("mult_neg", 2'd1, 32'hFFFFFFFD, 32'd7);
        chk("mult_neg_lo_out", o_MD_lo, 32'hFFFFFFEB);
        run_op("div_neg", 2'd3, 32'hFFFFFFF9, 32'd2);
        chk("div_neg_lo_out", o_MD_lo, 32'hFFFFFFFD);
        run_op("divu_zero", 2'd2, 32'd100, 32'd0);
        chk("divu_zero_hi_out", o_MD_hi, 32'd100);
        run_op("div_zero_neg", 2'd3, 32'hFFFFFF00, 32'd0);
        run_op("div_ovf", 2'd3, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_lo_out", o_MD_lo, 32'h80000000);
        run_op("mult_minint", 2'd1, 32'h80000000, 32'h80000000);

        // Start and MTLO during CALC are ignored
        launch(2'd2, 32'd17, 32'd5, 1'b0, 1'b0, 32'h0);
        repeat (4) @(negedge clk);
        launch(2'd0, 32'h1234, 32'h5678, 1'b0, 1'b1, 32'hDEADBEEF);
        wait_done("intf", 5, {32'd2, 32'd3});
        @(negedge clk);

        // Start with MTHI in IDLE: MTHI dropped (hold check at first busy cycle)
        launch(2'd0, 32'd6, 32'd7, 1'b1, 1'b0, 32'hBEEF0000);
        wait_done("start_mthi", 0, ref_md(2'd0, 32'd6, 32'd7));
        @(negedge clk);

        // Reset mid-CALC abandons the operation
        i_MD_mthi = 1'b1; i_MD_wdata = 32'h0000AAAA;
        @(negedge clk);
        i_MD_mthi = 1'b0; i_MD_mtlo = 1'b1; i_MD_wdata = 32'h00005555;
        @(negedge clk);
        i_MD_mtlo = 1'b0;
        chk("pre_rst_hi", o_MD_hi, 32'h0000AAAA);
        chk("pre_rst_lo", o_MD_lo, 32'h00005555);
        launch(2'd0, 32'd3, 32'd4, 1'b0, 1'b0, 32'h0);
        repeat (9) @(negedge clk);
        chk("mid_busy", o_MD_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", o_MD_busy, 1'b0);
        chk("midrst_hi", o_MD_hi, 32'h0);
        chk("midrst_lo", o_MD_lo, 32'h0);
        m_hi = 32'h0; m_lo = 32'h0;
        for (int i = 0; i < 30; i++) begin
            chk("midrst_no_done", o_MD_done, 1'b0);
            @(negedge clk);
        end
        chk("midrst_hi_after", o_MD_hi, 32'h0);

        // Back-to-back: start in the done cycle
        launch(2'd1, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0, 32'h0);
        wait_done("b2b_first", 0, ref_md(2'd1, 32'd5, 32'hFFFFFFFE));
        launch(2'd3, 32'd1000, 32'hFFFFFFF9, 1'b0, 1'b0, 32'h0);
        chk("b2b_busy", o_MD_busy, 1'b1);
        wait_done("b2b_second", 0, ref_md(2'd3, 32'd1000, 32'hFFFFFFF9));
        @(negedge clk);

        // Randomized operations against the arithmetic model
        for (int k = 0; k < 24; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                3: b = $urandom_range(1, 15);
                default: ;
            endcase
            launch(op, a, b, 1'b0, 1'b0, 32'h0);
            wait_done("rand", 0, ref_md(op, a, b));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk("rand_done_pulse", o_MD_done, 1'b0);
            end
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exe_muldiv_ctrl.md
Name: exe_muldiv_ctrl

Overview:
Iterative multiply/divide sequencer next to the EXE-stage ALU. It handles MULT, MULTU, DIV and DIVU. The block runs a 32-step shift-add or restoring-divide loop and raises a stall to the pipeline while the loop runs. Results land in the architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write.

Parameters:
WIDTH, 32, operand width and HI/LO width. The iteration count equals WIDTH.
CW, 5, width of the iteration counter. Must satisfy 2^CW >= WIDTH.

Ports:
clk  in  1  Single clock. All state updates on the rising edge.
rst  in  1  Synchronous reset, active-high. Sampled on the rising edge of clk.
i_MD_start  in  1  Start request from EXE. Valid for one cycle.
i_MD_op  in  2  Operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
i_MD_a  in  WIDTH  Operand A (rs): multiplicand or dividend.
i_MD_b  in  WIDTH  Operand B (rt): multiplier or divisor.
i_MD_mthi  in  1  Write i_MD_wdata into HI.
i_MD_mtlo  in  1  Write i_MD_wdata into LO.
i_MD_wdata  in  WIDTH  Data for MTHI/MTLO.
o_MD_busy  out  1  Stall request to the pipeline. High when state is not IDLE.
o_MD_done  out  1  One-cycle pulse. HI/LO are updated and valid on this cycle.
o_MD_hi  out  WIDTH  HI register.
o_MD_lo  out  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset: state goes to IDLE, counter to 0, internal accumulators to 0. o_MD_hi=0, o_MD_lo=0, o_MD_busy=0, o_MD_done=0.
- Reset mid-operation: the operation is abandoned with no HI/LO write. Reset wins over every other input in that cycle.
- FSM states are IDLE, CALC and FIX.
- IDLE with i_MD_start=1: latch the op. Latch |a| and |b| when the op is signed, else latch raw a and b. Record the result signs. Clear the accumulator, set count=0, go to CALC.
- CALC: one iteration per cycle.
  - MUL: 2*WIDTH product register. Add the multiplicand when the LSB is 1, then shift right.
  - DIV: restoring. Shift {rem,quo} left. Trial-subtract the divisor. Set the quotient bit when the result is >= 0.
  - count increments each cycle. The edge where count==WIDTH-1 moves to FIX. CALC lasts exactly WIDTH cycles.
- FIX:
  - Apply sign correction. MULT product is negated when sign(a)^sign(b). DIV quotient is negated when sign(a)^sign(b). Remainder takes the sign of the dividend.
  - Write HI/LO: MUL gives HI=product[63:32] and LO=product[31:0]. DIV gives LO=quotient and HI=remainder.
  - Go to IDLE. o_MD_done is registered high for the following cycle only.
- Latency: start sampled at edge E0. o_MD_busy is high for cycles E0+1 through E0+WIDTH+1 (33 cycles). HI/LO are written at edge E0+WIDTH+1. o_MD_done is high in the cycle after that edge, with busy already low.
- Start while busy: i_MD_start is ignored and the in-flight operation is unaffected.
- MTHI/MTLO:
  - Honoured only in IDLE, and only when i_MD_start=0.
  - Applied at the edge. Both may be asserted together.
  - When busy, or when i_MD_start=1 in the same cycle, they are ignored (start wins).
- Divide by zero (b=0): runs the full 33 cycles. LO=all-ones and HI=a, for both signed and unsigned.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (two's-complement wrap).
- The |x| of 0x80000000 is 0x80000000 when treated as unsigned. The magnitude datapath is unsigned, so the result is correct.
- HI/LO outputs hold their old values throughout CALC and FIX. They change only at the FIX edge, on MT writes, or on reset.
- Back-to-back operations: a new start is accepted in the o_MD_done cycle, since state is IDLE then.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> hi=lo=0, busy=0, done=0. MTHI with wdata=0x12345678 -> hi=0x12345678 next cycle, lo unchanged.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high exactly 33 cycles. Then done pulse with hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Interference during busy: mid-CALC assert i_MD_start with new operands plus mtlo=1 -> both ignored, original DIVU 17/5 gives lo=3, hi=2. Start with mthi in IDLE -> mthi dropped.
- Reset at CALC cycle 10 of MULTU 3*4, hi/lo previously 0xAAAA/0x5555 -> idle next cycle, hi=lo=0, no done pulse. Back-to-back start in the done cycle -> accepted, busy rises next cycle.
